alu_unit: RTL and testbench

32-bit, two-operand integer ALU for the RISC-V (RV32I) CPU execute stage. Implements the RV32I register/immediate arithmetic, logic, shift, compare and LUI pass-through operations, selected by a 4-bit opcode. The result is registered: one-cycle latency into the writeback path.

---
 rtl/alu_unit_pkg.sv | 20 ++
 rtl/alu_shifter.sv | 24 ++
 rtl/alu_unit.sv | 60 ++++++
 tb/tb_alu_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_unit_pkg.sv
// Shared ALU select encodings and datapath sizing for the RV32I execute stage.
// Imported by alu_unit, alu_shifter, the instruction decoder and the benches.
package alu_unit_pkg;

  localparam int unsigned AluWidth  = 32;
  localparam int unsigned AluShamtW = 5;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

endpackage

// File: rtl/alu_shifter.sv
// Combinational SLL/SRL/SRA unit; drives zero for any non-shift select.
module alu_shifter
  import alu_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic [3:0]         i_alusel,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [WIDTH-1:0]   o_result
);

  always_comb begin
    o_result = '0;
    case (i_alusel)
      ALU_SLL: o_result = i_data << i_shamt;
      ALU_SRL: o_result = i_data >> i_shamt;
      ALU_SRA: o_result = $unsigned($signed(i_data) >>> i_shamt);
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// RV32I two-operand ALU with a registered result (one-cycle latency).
// Synchronous active-high reset clears the result register.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic [3:0]       I_alusel,
  input  logic [WIDTH-1:0] I_data1,
  input  logic [WIDTH-1:0] I_data2,
  output logic [WIDTH-1:0] O_data
);

  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_data;

  // Only the low shift-amount bits of B reach the shifter; upper bits are ignored.
  alu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .i_alusel (I_alusel),
    .i_data   (I_data1),
    .i_shamt  (I_data2[SHAMT_W-1:0]),
    .o_result (w_shift)
  );

  always_comb begin
    w_result = '0;
    case (I_alusel)
      ALU_ADD:  w_result = I_data1 + I_data2;
      ALU_SUB:  w_result = I_data1 - I_data2;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  w_result = w_shift;
      ALU_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(I_data1) < $signed(I_data2))};
      ALU_SLTU: w_result = {{(WIDTH-1){1'b0}}, (I_data1 < I_data2)};
      ALU_XOR:  w_result = I_data1 ^ I_data2;
      ALU_OR:   w_result = I_data1 | I_data2;
      ALU_AND:  w_result = I_data1 & I_data2;
      ALU_LUI:  w_result = I_data2;
      default:  w_result = '0;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_data <= '0;
    end else begin
      r_data <= w_result;
    end
  end

  assign O_data = r_data;

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit: reset, op sweep, signed/unsigned cases,
// boundaries, equal operands and reset priority.
module tb_alu_unit;
  import alu_unit_pkg::*;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  alusel;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] dout;

  int checks;
  int fails;

  alu_unit #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .I_clk    (clk),
    .I_rst    (rst),
    .I_alusel (alusel),
    .I_data1  (data1),
    .I_data2  (data2),
    .O_data   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    alusel = sel;
    data1  = a;
    data2  = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(ALU_ADD, 32'd7, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dout !== 32'd0) begin
      $display("FAIL reset_hold: got %h expected %h", dout, 32'd0);
      fails++;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dout !== 32'd9) begin
      $display("FAIL reset_release_add: got %h expected %h", dout, 32'd9);
      fails++;
    end
  endtask

  // Each select is held for exactly one cycle; the old result must persist until the edge.
  task automatic test_sweep();
    vec_t        v[$];
    logic [31:0] prev;
    v.push_back('{ALU_ADD,  32'd7, 32'd2, 32'd9,  "add"});
    v.push_back('{ALU_SUB,  32'd7, 32'd2, 32'd5,  "sub"});
    v.push_back('{ALU_SLL,  32'd7, 32'd2, 32'd28, "sll"});
    v.push_back('{ALU_SLT,  32'd7, 32'd2, 32'd0,  "slt"});
    v.push_back('{ALU_SLTU, 32'd7, 32'd2, 32'd0,  "sltu"});
    v.push_back('{ALU_XOR,  32'd7, 32'd2, 32'd5,  "xor"});
    v.push_back('{ALU_SRL,  32'd7, 32'd2, 32'd1,  "srl"});
    v.push_back('{ALU_SRA,  32'd7, 32'd2, 32'd1,  "sra"});
    v.push_back('{ALU_OR,   32'd7, 32'd2, 32'd7,  "or"});
    v.push_back('{ALU_AND,  32'd7, 32'd2, 32'd2,  "and"});
    v.push_back('{ALU_LUI,  32'd7, 32'd2, 32'd2,  "lui"});
    prev = 32'd9;
    foreach (v[i]) begin
      drive(v[i].sel, v[i].a, v[i].b);
      #3;
      checks++;
      if (dout !== prev) begin
        $display("FAIL sweep_hold_%s: got %h expected %h", v[i].name, dout, prev);
        fails++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (dout !== v[i].exp) begin
        $display("FAIL sweep_%s: got %h expected %h", v[i].name, dout, v[i].exp);
        fails++;
      end
      prev = v[i].exp;
    end
  endtask

  task automatic test_signed();
    vec_t v[$];
    v.push_back('{ALU_SLT,  32'hFFFFFFFF, 32'd3, 32'd1,          "neg_slt"});
    v.push_back('{ALU_SLTU, 32'hFFFFFFFF, 32'd3, 32'd0,          "neg_sltu"});
    v.push_back('{ALU_SRL,  32'hFFFFFFFF, 32'd3, 32'h1FFFFFFF,   "neg_srl"});
    v.push_back('{ALU_SRA,  32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF,   "neg_sra"});
    v.push_back('{ALU_SUB,  32'hFFFFFFFF, 32'd3, 32'hFFFFFFFC,   "neg_sub"});
    v.push_back('{ALU_ADD,  32'hFFFFFFFF, 32'd3, 32'd2,          "neg_add"});
    v.push_back('{ALU_SLT,  32'd1, 32'hFFFFFFFD, 32'd0,          "pos_slt"});
    v.push_back('{ALU_SLTU, 32'd1, 32'hFFFFFFFD, 32'd1,          "pos_sltu"});
    v.push_back('{ALU_ADD,  32'd1, 32'hFFFFFFFD, 32'hFFFFFFFE,   "pos_add"});
    v.push_back('{ALU_SUB,  32'd1, 32'hFFFFFFFD, 32'd4,          "pos_sub"});
    v.push_back('{ALU_SLL,  32'd1, 32'hFFFFFFFD, 32'h20000000,   "pos_sll29"});
    foreach (v[i]) begin
      drive(v[i].sel, v[i].a, v[i].b);
      @(posedge clk);
      #1;
      checks++;
      if (dout !== v[i].exp) begin
        $display("FAIL signed_%s: got %h expected %h", v[i].name, dout, v[i].exp);
        fails++;
      end
    end
  endtask

  task automatic test_boundary();
    vec_t v[$];
    v.push_back('{ALU_ADD,  32'h7FFFFFFF, 32'd1,  32'h80000000, "add_ovf"});
    v.push_back('{ALU_SUB,  32'd0,        32'd1,  32'hFFFFFFFF, "sub_wrap"});
    v.push_back('{ALU_SRA,  32'h80000000, 32'd33, 32'hC0000000, "sra_33"});
    v.push_back('{ALU_SRL,  32'h80000000, 32'd33, 32'h40000000, "srl_33"});
    v.push_back('{ALU_SLL,  32'h00000001, 32'd31, 32'h80000000, "sll_31"});
    v.push_back('{ALU_LUI,  32'hDEADBEEF, 32'h12345000, 32'h12345000, "lui_ignore_a"});
    v.push_back('{4'd11,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,  "sel11"});
    v.push_back('{4'd15,    32'h12345678, 32'h9ABCDEF0, 32'd0,  "sel15"});
    foreach (v[i]) begin
      drive(v[i].sel, v[i].a, v[i].b);
      @(posedge clk);
      #1;
      checks++;
      if (dout !== v[i].exp) begin
        $display("FAIL boundary_%s: got %h expected %h", v[i].name, dout, v[i].exp);
        fails++;
      end
    end
  endtask

  task automatic test_equal();
    vec_t v[$];
    v.push_back('{ALU_SLT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        "slt"});
    v.push_back('{ALU_SLTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        "sltu"});
    v.push_back('{ALU_XOR,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        "xor"});
    v.push_back('{ALU_AND,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "and"});
    v.push_back('{ALU_SUB,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        "sub"});
    foreach (v[i]) begin
      drive(v[i].sel, v[i].a, v[i].b);
      @(posedge clk);
      #1;
      checks++;
      if (dout !== v[i].exp) begin
        $display("FAIL equal_%s: got %h expected %h", v[i].name, dout, v[i].exp);
        fails++;
      end
    end
  endtask

  // Reset asserted alongside a live operation must still clear, then resume next cycle.
  task automatic test_back_to_back();
    drive(ALU_OR, 32'hF0F0F0F0, 32'h0F0F0F0F);
    @(posedge clk);
    #1;
    checks++;
    if (dout !== 32'hFFFFFFFF) begin
      $display("FAIL b2b_or: got %h expected %h", dout, 32'hFFFFFFFF);
      fails++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dout !== 32'd0) begin
      $display("FAIL b2b_reset_wins: got %h expected %h", dout, 32'd0);
      fails++;
    end
    rst = 1'b0;
    drive(ALU_XOR, 32'hA5A5A5A5, 32'hFFFF0000);
    @(posedge clk);
    #1;
    checks++;
    if (dout !== 32'h5A5AA5A5) begin
      $display("FAIL b2b_xor_after_reset: got %h expected %h", dout, 32'h5A5AA5A5);
      fails++;
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    drive(ALU_ADD, 32'd0, 32'd0);
    test_reset();
    test_sweep();
    test_signed();
    test_boundary();
    test_equal();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
